// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, hazard freeze, synchronous
// flush, an optional one-entry skid buffer and a saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter bit                SKID      = 1'b1,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              FREEZE,
    input  logic              FLUSH,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              v_main_q, v_main_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              v_skid_q, v_skid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic adv;
    logic in_fire;
    logic out_fire;

    assign out_valid = v_main_q & ~FREEZE;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_cnt_q;
    assign out_fire  = out_valid & out_ready;

    // A frozen stage never advances, even while its main entry is empty.
    assign adv     = ~FREEZE & (~v_main_q | out_fire);
    assign in_fire = in_valid & in_ready;

    generate
        if (SKID) begin : g_skid_ready
            assign in_ready = ~v_skid_q;
        end else begin : g_comb_ready
            assign in_ready = adv;
        end
    endgenerate

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        v_main_d    = v_main_q;
        main_data_d = main_data_q;
        v_skid_d    = v_skid_q;
        skid_data_d = skid_data_q;

        if (FLUSH) begin
            v_main_d    = 1'b0;
            v_skid_d    = 1'b0;
            main_data_d = NOP_VALUE;
        end else if (adv) begin
            if (v_skid_q) begin
                // Parked payload is older than anything upstream, so it goes first.
                main_data_d = skid_data_q;
                v_main_d    = 1'b1;
                v_skid_d    = 1'b0;
            end else if (in_fire) begin
                main_data_d = in_data;
                v_main_d    = 1'b1;
            end else begin
                v_main_d = 1'b0;
            end
        end else if (in_fire && SKID) begin
            skid_data_d = in_data;
            v_skid_d    = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            v_main_q    <= 1'b0;
            main_data_q <= NOP_VALUE;
            v_skid_q    <= 1'b0;
            skid_data_q <= NOP_VALUE;
            stall_cnt_q <= '0;
        end else begin
            v_main_q    <= v_main_d;
            main_data_q <= main_data_d;
            v_skid_q    <= v_skid_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: SKID=1 (64-bit), SKID=0 (16-bit) and a
// CNT_W=4 instance sharing the SKID=1 stimulus; scoreboards track delivered order.
module tb_pipe_stage_reg;

    localparam logic [63:0] NOP_A = 64'h0000_0000_0000_0013;
    localparam logic [15:0] NOP_B = 16'h0013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // SKID=1 group (drives dut_a and dut_c)
    logic        a_valid, a_freeze, a_flush, a_oready;
    logic [63:0] a_data;
    logic        a_iready, a_ovalid;
    logic [63:0] a_odata;
    logic [15:0] a_cnt;
    logic        c_iready, c_ovalid;
    logic [63:0] c_odata;
    logic [3:0]  c_cnt;

    // SKID=0 group
    logic        b_valid, b_freeze, b_flush, b_oready;
    logic [15:0] b_data;
    logic        b_iready, b_ovalid;
    logic [15:0] b_odata;
    logic [15:0] b_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] q_a[$];
    logic [15:0] q_b[$];
    logic [63:0] exp_a;
    logic [15:0] exp_b;

    pipe_stage_reg #(.DATA_W(64), .NOP_VALUE(NOP_A), .SKID(1'b1), .CNT_W(16)) dut_a (
        .CLK(clk), .reset_n(rst_n),
        .in_valid(a_valid), .in_data(a_data), .in_ready(a_iready),
        .FREEZE(a_freeze), .FLUSH(a_flush),
        .out_valid(a_ovalid), .out_data(a_odata), .out_ready(a_oready),
        .stall_cnt(a_cnt)
    );

    pipe_stage_reg #(.DATA_W(64), .NOP_VALUE(NOP_A), .SKID(1'b1), .CNT_W(4)) dut_c (
        .CLK(clk), .reset_n(rst_n),
        .in_valid(a_valid), .in_data(a_data), .in_ready(c_iready),
        .FREEZE(a_freeze), .FLUSH(a_flush),
        .out_valid(c_ovalid), .out_data(c_odata), .out_ready(a_oready),
        .stall_cnt(c_cnt)
    );

    pipe_stage_reg #(.DATA_W(16), .NOP_VALUE(NOP_B), .SKID(1'b0), .CNT_W(16)) dut_b (
        .CLK(clk), .reset_n(rst_n),
        .in_valid(b_valid), .in_data(b_data), .in_ready(b_iready),
        .FREEZE(b_freeze), .FLUSH(b_flush),
        .out_valid(b_ovalid), .out_data(b_odata), .out_ready(b_oready),
        .stall_cnt(b_cnt)
    );

    // Scoreboards: push on accepted input, pop and compare on delivered output.
    // Sampled late in the low phase, after the directed checks of the same cycle.
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            if (a_ovalid && a_oready) begin
                tests_run++;
                if (q_a.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_a: got %0h, expected no delivery", a_odata);
                end else begin
                    exp_a = q_a.pop_front();
                    if (a_odata !== exp_a) begin
                        tests_failed++;
                        $display("FAIL sb_a: got %0h, expected %0h", a_odata, exp_a);
                    end
                end
            end
            if (a_flush) q_a.delete();
            else if (a_valid && a_iready) q_a.push_back(a_data);

            if (b_ovalid && b_oready) begin
                tests_run++;
                if (q_b.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_b: got %0h, expected no delivery", b_odata);
                end else begin
                    exp_b = q_b.pop_front();
                    if (b_odata !== exp_b) begin
                        tests_failed++;
                        $display("FAIL sb_b: got %0h, expected %0h", b_odata, exp_b);
                    end
                end
            end
            if (b_flush) q_b.delete();
            else if (b_valid && b_iready) q_b.push_back(b_data);
        end
    end

    always @(negedge rst_n) begin
        q_a.delete();
        q_b.delete();
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 0; a_freeze = 0; a_flush = 0; a_oready = 0; a_data = '0;
        b_valid = 0; b_freeze = 0; b_flush = 0; b_oready = 0; b_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_iready, a_odata, a_cnt} !== {1'b0, 1'b1, NOP_A, 16'd0}) begin
            tests_failed++;
            $display("FAIL reset_a: got v=%0b r=%0b d=%0h c=%0d, expected v=0 r=1 d=%0h c=0",
                     a_ovalid, a_iready, a_odata, a_cnt, NOP_A);
        end
        tests_run++;
        if ({b_ovalid, b_iready, b_odata, b_cnt} !== {1'b0, 1'b1, NOP_B, 16'd0}) begin
            tests_failed++;
            $display("FAIL reset_b: got v=%0b r=%0b d=%0h c=%0d, expected v=0 r=1 d=%0h c=0",
                     b_ovalid, b_iready, b_odata, b_cnt, NOP_B);
        end
        tests_run++;
        if ({c_odata, c_cnt} !== {NOP_A, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_c: got d=%0h c=%0d, expected d=%0h c=0", c_odata, c_cnt, NOP_A);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) begin
            a_valid  = (i < 8);
            a_data   = 64'(i + 1);
            a_oready = 1'b1;
            @(negedge clk);
            tests_run++;
            if (a_iready !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_ready[%0d]: got %0b, expected 1", i, a_iready);
            end
            tests_run++;
            if (i >= 1 && i <= 8) begin
                if ({a_ovalid, a_odata} !== {1'b1, 64'(i)}) begin
                    tests_failed++;
                    $display("FAIL stream_out[%0d]: got v=%0b d=%0h, expected v=1 d=%0h",
                             i, a_ovalid, a_odata, i);
                end
            end else if (a_ovalid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stream_idle[%0d]: got v=%0b, expected 0", i, a_ovalid);
            end
            next_cycle();
        end
        tests_run++;
        if (a_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL stream_cnt: got %0d, expected 0", a_cnt);
        end
    endtask

    task automatic test_freeze_skid();
        a_valid = 1; a_data = 64'hA; a_freeze = 0; a_oready = 0;
        next_cycle();
        a_freeze = 1; a_data = 64'hB; a_oready = 1;
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_iready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL freeze_absorb: got v=%0b r=%0b, expected v=0 r=1", a_ovalid, a_iready);
        end
        next_cycle();
        for (int j = 0; j < 3; j++) begin
            a_data = 64'hC;
            @(negedge clk);
            tests_run++;
            if ({a_ovalid, a_iready, a_cnt} !== {2'b00, 16'(j)}) begin
                tests_failed++;
                $display("FAIL freeze_hold[%0d]: got v=%0b r=%0b c=%0d, expected v=0 r=0 c=%0d",
                         j, a_ovalid, a_iready, a_cnt, j);
            end
            next_cycle();
        end
        a_freeze = 0;
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_iready, a_odata} !== {2'b10, 64'hA}) begin
            tests_failed++;
            $display("FAIL freeze_release: got v=%0b r=%0b d=%0h, expected v=1 r=0 d=a",
                     a_ovalid, a_iready, a_odata);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_iready, a_odata} !== {2'b11, 64'hB}) begin
            tests_failed++;
            $display("FAIL freeze_drain: got v=%0b r=%0b d=%0h, expected v=1 r=1 d=b",
                     a_ovalid, a_iready, a_odata);
        end
        next_cycle();
        a_valid = 0;
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_odata} !== {1'b1, 64'hC}) begin
            tests_failed++;
            $display("FAIL freeze_last: got v=%0b d=%0h, expected v=1 d=c", a_ovalid, a_odata);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_cnt, 32'(q_a.size())} !== {1'b0, 16'd4, 32'd0}) begin
            tests_failed++;
            $display("FAIL freeze_end: got v=%0b c=%0d pending=%0d, expected v=0 c=4 pending=0",
                     a_ovalid, a_cnt, q_a.size());
        end
        next_cycle();
    endtask

    task automatic test_flush();
        a_valid = 1; a_data = 64'hA; a_oready = 0; a_freeze = 0;
        next_cycle();
        a_data = 64'hB;
        next_cycle();
        a_data = 64'hC; a_freeze = 1; a_flush = 1;
        @(negedge clk);
        tests_run++;
        if (a_iready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_skid_full: got r=%0b, expected 0", a_iready);
        end
        next_cycle();
        a_flush = 0; a_freeze = 0; a_valid = 0; a_oready = 1;
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_iready, a_odata, a_cnt} !== {2'b01, NOP_A, 16'd5}) begin
            tests_failed++;
            $display("FAIL flush_empty: got v=%0b r=%0b d=%0h c=%0d, expected v=0 r=1 d=%0h c=5",
                     a_ovalid, a_iready, a_odata, a_cnt, NOP_A);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (a_ovalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_no_c: got v=%0b, expected 0", a_ovalid);
        end
        next_cycle();

        // Back-to-back flushes with input offered each time.
        a_valid = 1; a_data = 64'hD; a_oready = 0;
        next_cycle();
        a_flush = 1; a_data = 64'hE;
        next_cycle();
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_odata} !== {1'b0, NOP_A}) begin
            tests_failed++;
            $display("FAIL flush_b2b_1: got v=%0b d=%0h, expected v=0 d=%0h", a_ovalid, a_odata, NOP_A);
        end
        next_cycle();
        a_flush = 0; a_valid = 0;
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_odata} !== {1'b0, NOP_A}) begin
            tests_failed++;
            $display("FAIL flush_b2b_2: got v=%0b d=%0h, expected v=0 d=%0h", a_ovalid, a_odata, NOP_A);
        end
        next_cycle();

        // Flush coinciding with a downstream transfer still delivers that payload.
        a_valid = 1; a_data = 64'hF; a_oready = 0;
        next_cycle();
        a_valid = 0; a_flush = 1; a_oready = 1;
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_odata} !== {1'b1, 64'hF}) begin
            tests_failed++;
            $display("FAIL flush_fire: got v=%0b d=%0h, expected v=1 d=f", a_ovalid, a_odata);
        end
        next_cycle();
        a_flush = 0;
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_odata, a_cnt, 32'(q_a.size())} !== {1'b0, NOP_A, 16'd5, 32'd0}) begin
            tests_failed++;
            $display("FAIL flush_end: got v=%0b d=%0h c=%0d pending=%0d, expected v=0 d=%0h c=5 pending=0",
                     a_ovalid, a_odata, a_cnt, q_a.size(), NOP_A);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        a_valid = 1; a_data = 64'h1A; a_oready = 0; a_freeze = 0;
        next_cycle();
        a_data = 64'h1B;
        next_cycle();
        a_valid = 0;
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_iready, a_cnt} !== {2'b10, 16'd5}) begin
            tests_failed++;
            $display("FAIL rstmid_pre: got v=%0b r=%0b c=%0d, expected v=1 r=0 c=5",
                     a_ovalid, a_iready, a_cnt);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({a_ovalid, a_odata, a_cnt, c_cnt} !== {1'b0, NOP_A, 16'd0, 4'd0}) begin
            tests_failed++;
            $display("FAIL rstmid_async: got v=%0b d=%0h c=%0d c4=%0d, expected v=0 d=%0h c=0 c4=0",
                     a_ovalid, a_odata, a_cnt, c_cnt, NOP_A);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({a_ovalid, a_iready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rstmid_post: got v=%0b r=%0b, expected v=0 r=1", a_ovalid, a_iready);
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        int exp_cnt;
        a_valid = 1; a_data = 64'h55; a_freeze = 1; a_oready = 0;
        for (int j = 0; j <= 20; j++) begin
            @(negedge clk);
            exp_cnt = (j == 0) ? 0 : j - 1;
            if (exp_cnt > 15) exp_cnt = 15;
            tests_run++;
            if ({c_ovalid, c_iready, c_cnt} !== {1'b0, (j == 0), 4'(exp_cnt)}) begin
                tests_failed++;
                $display("FAIL sat[%0d]: got v=%0b r=%0b c4=%0d, expected v=0 r=%0b c4=%0d",
                         j, c_ovalid, c_iready, c_cnt, (j == 0), exp_cnt);
            end
            if (j == 20) begin
                tests_run++;
                if (a_cnt !== 16'd19) begin
                    tests_failed++;
                    $display("FAIL sat_wide: got %0d, expected 19", a_cnt);
                end
            end
            next_cycle();
        end
        a_valid = 0; a_flush = 1;
        next_cycle();
        a_flush = 0; a_freeze = 0;
    endtask

    task automatic test_backpressure();
        logic exp_rdy;
        logic exp_v;
        b_valid = 1; b_data = 16'h11; b_oready = 0; b_freeze = 0; b_flush = 0;
        @(negedge clk);
        tests_run++;
        if (b_iready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_empty: got r=%0b, expected 1", b_iready);
        end
        next_cycle();
        b_data = 16'h22;
        @(negedge clk);
        tests_run++;
        if (b_iready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_full: got r=%0b, expected 0", b_iready);
        end
        #1 b_oready = 1'b1;
        #1;
        tests_run++;
        if (b_iready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: got r=%0b, expected 1", b_iready);
        end
        next_cycle();
        b_valid = 0;
        @(negedge clk);
        tests_run++;
        if ({b_ovalid, b_odata} !== {1'b1, 16'h22}) begin
            tests_failed++;
            $display("FAIL bp_second: got v=%0b d=%0h, expected v=1 d=22", b_ovalid, b_odata);
        end
        next_cycle();

        for (int n = 0; n < 100; n++) begin
            b_valid  = 1'($urandom_range(0, 1));
            b_data   = 16'($urandom);
            b_oready = 1'($urandom_range(0, 1));
            b_freeze = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            exp_v   = (q_b.size() != 0) && !b_freeze;
            exp_rdy = !b_freeze && ((q_b.size() == 0) || b_oready);
            tests_run++;
            if ({b_ovalid, b_iready} !== {exp_v, exp_rdy}) begin
                tests_failed++;
                $display("FAIL bp_rand[%0d]: got v=%0b r=%0b, expected v=%0b r=%0b",
                         n, b_ovalid, b_iready, exp_v, exp_rdy);
            end
            next_cycle();
        end
        b_valid = 0; b_freeze = 0; b_oready = 1;
        repeat (2) next_cycle();
        @(negedge clk);
        tests_run++;
        if ({b_ovalid, 32'(q_b.size())} !== {1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL bp_drain: got v=%0b pending=%0d, expected v=0 pending=0",
                     b_ovalid, q_b.size());
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_freeze_skid();
        test_flush();
        test_reset_mid();
        test_saturation();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready flow control, hazard freeze, synchronous flush and an optional one-entry skid buffer. It replaces fixed-width IF/ID-style latches between any two pipeline stages: IF/ID, ID/EX, EX/MEM and MEM/WB. Payload width, bubble value and upstream-ready timing are set per instance. A saturating stall counter supports performance debug.

## Interface
Parameters:
- DATA_W, 64: payload width in bits, e.g. {IR, PCp4}.
- NOP_VALUE, {DATA_W{1'b0}}: payload value loaded on reset and flush.
- SKID, 1: 1 = include skid entry and registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- CLK, input, 1: single clock. All state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: upstream payload valid.
- in_data, input, DATA_W: upstream payload.
- in_ready, output, 1: stage can accept. in_fire = in_valid & in_ready.
- FREEZE, input, 1: hazard stall. Holds the main entry.
- FLUSH, input, 1: synchronous kill of all held entries.
- out_valid, output, 1: held payload valid = v_main & ~FREEZE.
- out_data, output, DATA_W: main entry payload, registered.
- out_ready, input, 1: downstream accepts. out_fire = out_valid & out_ready.
- stall_cnt, output, CNT_W: count of cycles with in_valid & ~in_ready.

## Operation
- State:
  - main entry: v_main, out_data.
  - skid entry, only when SKID=1: v_skid, skid_data.
  - stall_cnt.
- adv = ~v_main | out_fire. This is the condition under which the main entry may be overwritten this cycle. FREEZE=1 forces adv = ~v_main & 0 … effectively: FREEZE=1 means adv=0, and the main entry holds even if it is empty.
- in_ready:
  - SKID=0: in_ready = ~FREEZE & adv. Combinational.
  - SKID=1: in_ready = ~v_skid. Registered; independent of FREEZE and out_ready.
- Per-cycle priority, highest first:
  1. reset_n=0, asynchronous: v_main=0, v_skid=0, out_data=NOP_VALUE, skid_data=NOP_VALUE, stall_cnt=0.
  2. FLUSH=1: v_main=0, v_skid=0, out_data=NOP_VALUE.
     - An in_fire in the same cycle is consumed and discarded.
     - out_fire in the same cycle still counts as a transfer to downstream.
  3. adv=1 and v_skid=1: main loads skid_data; v_skid=0.
  4. adv=1 and v_skid=0 and in_fire: main loads in_data; v_main=1.
  5. adv=1 and no source: v_main=0; out_data holds its last value.
  6. adv=0 and in_fire (SKID=1 only): skid loads in_data; v_skid=1.
  7. Otherwise: hold.
- Ordering: payloads leave in acceptance order. The skid entry is always drained before new input.
- Combination check: with SKID=1, in_fire and v_skid=1 cannot occur together, since in_ready=0 whenever the skid entry is full.
- stall_cnt:
  - +1 every cycle with in_valid=1 & in_ready=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; FLUSH does not clear it.
- FLUSH is not gated by FREEZE. FLUSH=1 with FREEZE=1 still empties the stage.

## Timing
- Latency, in_fire to out_valid:
  - 1 cycle when the stage is empty.
  - 2 cycles when the payload was parked in skid.
- Throughput: 1 payload/cycle sustained with out_ready=1 and FREEZE=0, for both SKID values.
- SKID=1: in_ready falls 1 cycle after the skid entry fills. It rises the cycle after the skid entry drains.
- FREEZE assert, SKID=1: exactly one further payload is absorbed into skid, then in_ready=0.
- FREEZE release: the first out_fire is possible in the same cycle FREEZE goes low.
- Reset deassertion: first in_fire is possible on the first rising edge after reset_n rises (in_ready=1 out of reset).
- Back-to-back flushes: each one leaves the stage empty with out_data=NOP_VALUE.

## Test plan
- Stream, SKID=1, DATA_W=64:
  - Stimulus: in_valid=1 for 8 cycles with data 0x1..0x8; out_ready=1, FREEZE=0.
  - Required: out_data equals 0x1..0x8 on consecutive cycles starting 1 cycle after the first in_fire; stall_cnt=0.
- Freeze skid, SKID=1:
  - Stimulus: load 0xA, then hold FREEZE=1 while offering 0xB and 0xC.
  - Required: 0xB is absorbed into skid and in_ready drops; out_valid=0 during FREEZE; stall_cnt increments by 1 per frozen cycle with in_valid=1.
  - After release: 0xA, 0xB, 0xC are delivered in order.
- Flush, SKID=1:
  - Stimulus: main=0xA, skid=0xB; pulse FLUSH=1 with FREEZE=1 and in_data=0xC offered.
  - Required: next cycle v_main=0, out_valid=0, out_data=NOP_VALUE, in_ready=1; 0xC is never delivered.
- Backpressure, SKID=0:
  - Stimulus: out_ready=0 with the main entry full.
  - Required: in_ready=0 in the same cycle.
  - Stimulus: out_ready=1.
  - Required: in_ready=1 in the same cycle; no payload is dropped or duplicated over 100 random ready/valid cycles.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 asynchronously between edges with both entries full and stall_cnt=5.
  - Required: immediately out_valid=0, out_data=NOP_VALUE, stall_cnt=0; in_ready=1 after release.
- Counter saturation, CNT_W=4:
  - Stimulus: in_valid=1, FREEZE=1 held for 20 cycles.
  - Required: stall_cnt reaches 15 and holds at 15.
